binary_bcd_seq_convertor: RTL and testbench
===========================================

Name: binary_bcd_seq_convertor

Overview:
- Sequential binary-to-BCD converter using the double-dabble (shift-and-add-3) algorithm, processing one bit per clock.
- It is the forward counterpart of the combinational BCD-to-binary convertor in the BCD hardware library.
- It feeds BCD display/formatting paths from binary datapaths.
- Valid/ready handshake on input and output; one conversion in flight at a time.

Parameters:
- WIDTH, 8, bit width of the binary input.
- DIGITS, 3, number of BCD output digits. Must satisfy 10**DIGITS > 2**WIDTH - 1. Elaboration fails with $error otherwise.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  x is valid this cycle.
- in_ready  output  1  converter idle and able to accept x.
- x  input  WIDTH  unsigned binary operand, sampled on the accept edge.
- out_valid  output  1  y holds a completed result.
- out_ready  input  1  consumer accepts y.
- y  output  4*DIGITS  packed BCD result, most-significant digit in the top nibble.

Behaviour:
- Reset (asynchronous, takes priority over everything):
  - state=IDLE, bin_reg=0, bcd_reg=0, count=0, out_valid=0, y=0.
  - in_ready=1 while in reset, because it decodes from state.
- State IDLE:
  - in_ready=1.
  - Accept edge: in_valid=1. On that edge bin_reg<=x, bcd_reg<=0, count<=WIDTH, next state SHIFT.
- State SHIFT:
  - in_ready=0, out_valid=0.
  - Each edge:
    - every 4-bit digit of bcd_reg that is >=5 gets +3 (all digits corrected in parallel, from the pre-shift value);
    - then {bcd_reg,bin_reg} shifts left by 1;
    - count decrements.
  - On the edge where count==1, the final shift completes and next state is DONE.
  - Exactly WIDTH SHIFT edges occur.
- State DONE:
  - out_valid=1, y=bcd_reg, in_ready=0.
  - y holds stable while out_valid=1 and out_ready=0.
  - On an edge with out_ready=1, next state IDLE and out_valid deasserts.
- Latency:
  - out_valid rises WIDTH cycles after the accept edge.
  - Minimum accept-to-accept interval is WIDTH+2 cycles: WIDTH shifts, one DONE handshake cycle, one IDLE accept cycle.
  - No bypass of the DONE handshake.
- Register behaviour:
  - y is a registered copy of bcd_reg.
  - y keeps its last value after the handshake until the next DONE state. It is only meaningful while out_valid=1.
- Input handling outside IDLE:
  - in_valid while in SHIFT or DONE is ignored.
  - x changes after the accept edge have no effect.
- Arithmetic:
  - Add-3 is done per nibble with no carry between nibbles.
  - Given the DIGITS constraint, the top digit never exceeds 9 and no overflow flag is needed.
- Reset mid-conversion (SHIFT or DONE): returns to IDLE immediately. The partial result is discarded and no out_valid pulse is produced.
- Boundary values:
  - x=0 yields y=0.
  - x=2**WIDTH-1 yields the full-scale decimal value.
  - WIDTH=1 is legal (DIGITS=1, one SHIFT cycle).

Test Plan:
- WIDTH=8: accept x=8'd255, out_ready=1 -> out_valid rises 8 cycles after accept, y=12'h255, in_ready returns 1 the next cycle.
- Accept x=0, then x=8'd99, then x=8'd100 back-to-back with in_valid held high -> y=12'h000, 12'h099, 12'h100 in order. Each accept is spaced 10 cycles apart.
- Back-pressure: x=8'd42, out_ready held 0 for 6 cycles after out_valid -> y stays 12'h042, in_ready stays 0. A new in_valid with x=8'd7 during this window is ignored. y updates to 12'h007 only after the handshake and a fresh accept.
- Assert rst for 1 cycle during the 4th SHIFT cycle of x=8'd200 -> state IDLE asynchronously, y=0, out_valid never pulses. The next conversion of x=8'd13 yields 12'h013.
- Exhaustive sweep x=0..255, checking y against a reference model using digit-wise decimal -> 256/256 match, each with latency exactly 8.
- Parameter set WIDTH=16, DIGITS=5: x=16'd65535 -> y=20'h65535 after 16 cycles; x=16'd1000 -> y=20'h01000.

Source files
------------

// File: rtl/binary_bcd_seq_convertor_if.sv
// rtl/binary_bcd_seq_convertor_if.sv - input/output handshake bundle for the binary-to-BCD converter
interface binary_bcd_seq_convertor_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
);
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      x;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   y;

    modport master (
        output in_valid, x, out_ready,
        input  in_ready, out_valid, y
    );

    modport slave (
        input  in_valid, x, out_ready,
        output in_ready, out_valid, y
    );
endinterface

// File: rtl/binary_bcd_seq_convertor.sv
// rtl/binary_bcd_seq_convertor.sv - sequential double-dabble binary-to-BCD converter, one bit per clock
module binary_bcd_seq_convertor #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    binary_bcd_seq_convertor_if.slave   conv
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int BW = 4 * DIGITS;

    if (longint'(10) ** DIGITS <= (longint'(1) << WIDTH) - 1) begin : g_bad_digits
        $error("binary_bcd_seq_convertor: DIGITS too small to hold 2**WIDTH-1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_e;

    state_e                state_q, state_d;
    logic [WIDTH-1:0]      bin_q, bin_d;
    logic [BW-1:0]         bcd_q, bcd_d;
    logic [BW-1:0]         y_q, y_d;
    logic [CW-1:0]         count_q, count_d;
    logic [BW-1:0]         corr;
    logic [BW+WIDTH-1:0]   shifted;

    // Add-3 is applied per nibble on the pre-shift value; no carry crosses nibbles.
    always_comb begin
        corr = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                corr[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        shifted = {corr, bin_q} << 1;
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        count_d = count_q;
        y_d     = y_q;
        case (state_q)
            S_IDLE: begin
                if (conv.in_valid) begin
                    bin_d   = conv.x;
                    bcd_d   = '0;
                    count_d = CW'(WIDTH);
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                bcd_d   = shifted[BW+WIDTH-1:WIDTH];
                bin_d   = shifted[WIDTH-1:0];
                count_d = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    y_d     = shifted[BW+WIDTH-1:WIDTH];
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (conv.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            count_q <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            count_q <= count_d;
            y_q     <= y_d;
        end
    end

    assign conv.in_ready  = (state_q == S_IDLE);
    assign conv.out_valid = (state_q == S_DONE);
    assign conv.y         = y_q;

endmodule

// File: tb/tb_binary_bcd_seq_convertor.sv
// tb/tb_binary_bcd_seq_convertor.sv - randomized self-checking bench against a decimal reference model
module tb_binary_bcd_seq_convertor;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    binary_bcd_seq_convertor_if #(.WIDTH(8),  .DIGITS(3)) i8 ();
    binary_bcd_seq_convertor_if #(.WIDTH(16), .DIGITS(5)) i16 ();

    binary_bcd_seq_convertor #(.WIDTH(8), .DIGITS(3)) dut8 (
        .clk  (clk),
        .rst  (rst),
        .conv (i8.slave)
    );

    binary_bcd_seq_convertor #(.WIDTH(16), .DIGITS(5)) dut16 (
        .clk  (clk),
        .rst  (rst),
        .conv (i16.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [63:0] exp_q[$];
    int          acc_q[$];
    bit          prev_ov = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] bcd_ref(input longint unsigned v, input int digits);
        logic [63:0] r;
        longint unsigned n;
        r = '0;
        n = v;
        for (int i = 0; i < digits; i++) begin
            r[4*i +: 4] = 4'(n % 10);
            n = n / 10;
        end
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard for the 8-bit instance, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            acc_q.delete();
            prev_ov = 1'b0;
        end else begin
            if (i8.out_valid && !prev_ov) begin
                if (acc_q.size() == 0) chk("spurious_out_valid", 64'd1, 64'd0);
                else chk("latency8", 64'(cyc - acc_q.pop_front()), 64'd8);
            end
            if (i8.out_valid && i8.out_ready) begin
                if (exp_q.size() == 0) chk("unexpected_output", 64'd1, 64'd0);
                else chk("y8_value", 64'(i8.y), exp_q.pop_front());
            end
            if (i8.in_valid && i8.in_ready) begin
                exp_q.push_back(bcd_ref(64'(i8.x), 3));
                acc_q.push_back(cyc + 1);
            end
            prev_ov = i8.out_valid;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready8();
        int g;
        g = 0;
        while (!i8.in_ready && g < 60) begin
            tick();
            g++;
        end
        if (!i8.in_ready) chk("ready_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_valid8(output int lat);
        lat = 0;
        while (!i8.out_valid && lat < 60) begin
            tick();
            lat++;
        end
        if (!i8.out_valid) chk("valid_timeout", 64'd0, 64'd1);
    endtask

    task automatic send8(input logic [7:0] v);
        wait_ready8();
        i8.in_valid = 1'b1;
        i8.x        = v;
        tick();
        i8.in_valid = 1'b0;
        i8.x        = 8'($urandom);
    endtask

    initial begin
        int lat;
        int acc_t[3];
        logic [7:0] vals[3];
        int order[256];
        int bp;
        bit seen;
        longint unsigned v16[6];

        i8.in_valid  = 1'b0;
        i8.x         = '0;
        i8.out_ready = 1'b1;
        i16.in_valid = 1'b0;
        i16.x        = '0;
        i16.out_ready = 1'b1;

        repeat (2) tick();
        chk("rst_in_ready", 64'(i8.in_ready), 64'd1);
        chk("rst_out_valid", 64'(i8.out_valid), 64'd0);
        chk("rst_y", 64'(i8.y), 64'd0);
        chk("rst_y16", 64'(i16.y), 64'd0);
        rst = 1'b0;
        tick();

        // Full-scale value with immediate consumer.
        send8(8'd255);
        wait_valid8(lat);
        chk("fs_latency", 64'(lat), 64'd8);
        chk("fs_y", 64'(i8.y), 64'h255);
        tick();
        chk("fs_ready_back", 64'(i8.in_ready), 64'd1);

        // Back-to-back accepts with in_valid held high.
        vals[0] = 8'd0; vals[1] = 8'd99; vals[2] = 8'd100;
        i8.in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_ready8();
            i8.x = vals[k];
            tick();
            acc_t[k] = cyc;
        end
        i8.in_valid = 1'b0;
        wait_valid8(lat);
        chk("b2b_last_y", 64'(i8.y), 64'h100);
        tick();
        chk("b2b_spacing_a", 64'(acc_t[1] - acc_t[0]), 64'd10);
        chk("b2b_spacing_b", 64'(acc_t[2] - acc_t[1]), 64'd10);

        // Back-pressure; in_valid during DONE must be ignored.
        i8.out_ready = 1'b0;
        send8(8'd42);
        wait_valid8(lat);
        for (int i = 0; i < 6; i++) begin
            if (i == 1) begin
                i8.in_valid = 1'b1;
                i8.x        = 8'd7;
            end
            chk("bp_y_stable", 64'(i8.y), 64'h042);
            chk("bp_in_ready", 64'(i8.in_ready), 64'd0);
            tick();
        end
        i8.in_valid  = 1'b0;
        chk("bp_still_valid", 64'(i8.out_valid), 64'd1);
        i8.out_ready = 1'b1;
        tick();
        chk("bp_y_kept", 64'(i8.y), 64'h042);
        chk("bp_ready_back", 64'(i8.in_ready), 64'd1);
        send8(8'd7);
        wait_valid8(lat);
        chk("bp_new_y", 64'(i8.y), 64'h007);
        tick();

        // Asynchronous reset in the 4th SHIFT cycle.
        send8(8'd200);
        repeat (3) tick();
        rst = 1'b1;
        #1;
        chk("async_rst_ready", 64'(i8.in_ready), 64'd1);
        chk("async_rst_valid", 64'(i8.out_valid), 64'd0);
        chk("async_rst_y", 64'(i8.y), 64'd0);
        tick();
        rst = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            tick();
            if (i8.out_valid) seen = 1'b1;
        end
        chk("rst_no_valid_pulse", 64'(seen), 64'd0);
        send8(8'd13);
        wait_valid8(lat);
        chk("post_rst_y", 64'(i8.y), 64'h013);
        tick();

        // Shuffled exhaustive sweep with random consumer stalls.
        for (int i = 0; i < 256; i++) order[i] = i;
        for (int i = 255; i > 0; i--) begin
            int j, t;
            j = int'($urandom_range(0, i));
            t = order[i]; order[i] = order[j]; order[j] = t;
        end
        for (int i = 0; i < 256; i++) begin
            bp = int'($urandom_range(0, 3));
            i8.out_ready = (bp == 0);
            send8(8'(order[i]));
            wait_valid8(lat);
            repeat (bp) tick();
            i8.out_ready = 1'b1;
            wait_ready8();
        end
        repeat (2) tick();
        chk("sweep_pending", 64'(exp_q.size()), 64'd0);

        // 16-bit instance.
        v16[0] = 65535; v16[1] = 1000; v16[2] = 0;
        for (int k = 3; k < 6; k++) v16[k] = longint'($urandom_range(0, 65535));
        for (int k = 0; k < 6; k++) begin
            int g;
            g = 0;
            while (!i16.in_ready && g < 60) begin
                tick();
                g++;
            end
            i16.in_valid = 1'b1;
            i16.x        = 16'(v16[k]);
            tick();
            i16.in_valid = 1'b0;
            lat = 0;
            while (!i16.out_valid && lat < 60) begin
                tick();
                lat++;
            end
            chk("w16_latency", 64'(lat), 64'd16);
            chk("w16_y", 64'(i16.y), bcd_ref(v16[k], 5));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
